// File: rtl/sad_buf_fill_ctrl.sv
// sad_buf_fill_ctrl: fills the two SAD operand buffers (A = window, B = frame)
// from data memory over a read port shared with the pipeline MEM stage.
// Rows are read one 32-bit word at a time. Each read returns exactly one
// cycle later and is written into the buffer row its tag names.
// all_buf_flags releases the decode-stage stall once both buffers are valid.
// Optional feature macro: SAD_BUF_FILL_STATS_EN adds the 16-bit stall_cnt
// output, a saturating count of fill cycles blocked by mem_busy.
module sad_buf_fill_ctrl #(
  parameter int ROWS = 4,
  parameter int RW   = 2
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            start,
  input  logic [31:0]     base_a,
  input  logic [31:0]     base_b,
  input  logic [15:0]     stride,
  input  logic            mem_busy,
  output logic            mem_rd,
  output logic [31:0]     mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic            buf_we,
  output logic            buf_sel,
  output logic [RW-1:0]   buf_row,
  output logic [31:0]     buf_wdata,
  output logic [ROWS-1:0] flags_a,
  output logic [ROWS-1:0] flags_b,
  output logic            all_buf_flags,
`ifdef SAD_BUF_FILL_STATS_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_A = 2'd1,
    FILL_B = 2'd2,
    DRAIN  = 2'd3
  } stateE;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  stateE           state_q, state_d;
  logic [31:0]     ptr_q, ptr_d;
  logic [RW-1:0]   row_q, row_d;
  logic [31:0]     baseB_q, baseB_d;
  logic [31:0]     stride_q, stride_d;
  logic            tagValid_q, tagValid_d;
  logic            tagSel_q, tagSel_d;
  logic [RW-1:0]   tagRow_q, tagRow_d;
  logic [ROWS-1:0] flagsA_q, flagsA_d;
  logic [ROWS-1:0] flagsB_q, flagsB_d;

  logic inFill;
  logic issue;
  logic writeEn;

  // Issue/return qualifiers shared by the next-state logic and the outputs
  always_comb begin
    inFill  = (state_q == FILL_A) || (state_q == FILL_B);
    issue   = inFill && !mem_busy;
    writeEn = tagValid_q && !start;
  end

  // Next-state logic: sequencing, pointer walk, return tag and flag updates;
  // a start pulse overrides everything else and kills any in-flight read
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    row_d      = row_q;
    baseB_d    = baseB_q;
    stride_d   = stride_q;
    flagsA_d   = flagsA_q;
    flagsB_d   = flagsB_q;
    tagValid_d = issue;
    tagSel_d   = (state_q == FILL_B);
    tagRow_d   = row_q;

    if (writeEn) begin
      if (tagSel_q) begin
        flagsB_d[tagRow_q] = 1'b1;
      end else begin
        flagsA_d[tagRow_q] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FILL_A: begin
        if (issue) begin
          if (row_q == LAST_ROW) begin
            ptr_d   = baseB_q;
            row_d   = '0;
            state_d = FILL_B;
          end else begin
            ptr_d = ptr_q + stride_q;
            row_d = row_q + RW'(1);
          end
        end
      end
      FILL_B: begin
        if (issue) begin
          ptr_d = ptr_q + stride_q;
          row_d = row_q + RW'(1);
          if (row_q == LAST_ROW) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d    = FILL_A;
      ptr_d      = base_a;
      row_d      = '0;
      baseB_d    = base_b;
      stride_d   = {16'h0000, stride};
      flagsA_d   = '0;
      flagsB_d   = '0;
      tagValid_d = 1'b0;
    end
  end

  // State, pointer, latched configuration, return tag and flag registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      row_q      <= '0;
      baseB_q    <= '0;
      stride_q   <= '0;
      tagValid_q <= 1'b0;
      tagSel_q   <= 1'b0;
      tagRow_q   <= '0;
      flagsA_q   <= '0;
      flagsB_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      row_q      <= row_d;
      baseB_q    <= baseB_d;
      stride_q   <= stride_d;
      tagValid_q <= tagValid_d;
      tagSel_q   <= tagSel_d;
      tagRow_q   <= tagRow_d;
      flagsA_q   <= flagsA_d;
      flagsB_q   <= flagsB_d;
    end
  end

`ifdef SAD_BUF_FILL_STATS_EN
  logic [15:0] stallCnt_q, stallCnt_d;

  // Saturating count of fill cycles where the pipeline holds the read port
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (start) begin
      stallCnt_d = '0;
    end else if (inFill && mem_busy && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

  assign mem_rd        = issue;
  assign mem_addr      = ptr_q;
  assign buf_we        = writeEn;
  assign buf_sel       = writeEn & tagSel_q;
  assign buf_row       = writeEn ? tagRow_q : '0;
  assign buf_wdata     = writeEn ? mem_rdata : '0;
  assign flags_a       = flagsA_q;
  assign flags_b       = flagsB_q;
  assign all_buf_flags = (&flagsA_q) & (&flagsB_q);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sad_buf_fill_ctrl.sv
// tb_sad_buf_fill_ctrl: directed bench for sad_buf_fill_ctrl (ROWS=4).
// A one-cycle-latency memory returns addr ^ 32'h5A5A0F0F for every read.
module tb_sad_buf_fill_ctrl;

  localparam int ROWS = 4;
  localparam int RW   = 2;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic            start;
  logic [31:0]     base_a;
  logic [31:0]     base_b;
  logic [15:0]     stride;
  logic            mem_busy;
  logic            mem_rd;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_rdata = 32'h0;
  logic            buf_we;
  logic            buf_sel;
  logic [RW-1:0]   buf_row;
  logic [31:0]     buf_wdata;
  logic [ROWS-1:0] flags_a;
  logic [ROWS-1:0] flags_b;
  logic            all_buf_flags;
  logic            busy;
`ifdef SAD_BUF_FILL_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  sad_buf_fill_ctrl #(.ROWS(ROWS), .RW(RW)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .start         (start),
    .base_a        (base_a),
    .base_b        (base_b),
    .stride        (stride),
    .mem_busy      (mem_busy),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .buf_we        (buf_we),
    .buf_sel       (buf_sel),
    .buf_row       (buf_row),
    .buf_wdata     (buf_wdata),
    .flags_a       (flags_a),
    .flags_b       (flags_b),
    .all_buf_flags (all_buf_flags),
`ifdef SAD_BUF_FILL_STATS_EN
    .stall_cnt     (stall_cnt),
`endif
    .busy          (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A0F0F;
  endfunction

  // Memory: data for the address read this cycle appears next cycle
  always @(posedge Clk) begin
    if (mem_rd === 1'b1) mem_rdata <= memData(mem_addr);
  end

  function automatic logic [31:0] addrOf(input logic [31:0] ba, input logic [31:0] bb,
                                         input logic [15:0] st, input int idx);
    logic [31:0] rowOff;
    rowOff = 32'(idx % ROWS) * {16'h0000, st};
    return (idx < ROWS) ? (ba + rowOff) : (bb + rowOff);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] ba, input logic [31:0] bb,
                               input logic [15:0] st, input logic mb);
    start    = s;
    base_a   = ba;
    base_b   = bb;
    stride   = st;
    mem_busy = mb;
  endtask

  // Pulse start at the next negedge, then walk nCycles cycles checking
  // issues, returns, flags and completion against the read-order model.
  task automatic runFill(input logic [31:0] ba, input logic [31:0] bb, input logic [15:0] st,
                         input int busyLo, input int busyHi, input int expDone,
                         input int nCycles);
    int   issued;
    int   prev;
    logic blocked;
    logic expRd;
    @(negedge Clk);
    applyStimulus(1'b1, ba, bb, st, 1'b0);
    #1;
    checkOutput("startNoWrite", buf_we, 0);
    issued = 0;
    prev   = -1;
    for (int k = 1; k <= nCycles; k++) begin
      @(negedge Clk);
      blocked = (k >= busyLo) && (k <= busyHi);
      applyStimulus(1'b0, ba, bb, st, blocked);
      #1;
      expRd = (issued < 2 * ROWS) && !blocked;
      checkOutput("memRd", mem_rd, expRd);
      if (expRd) checkOutput("memAddr", mem_addr, addrOf(ba, bb, st, issued));
      checkOutput("bufWe", buf_we, (prev >= 0));
      if (prev >= 0) begin
        checkOutput("bufSel", buf_sel, (prev >= ROWS));
        checkOutput("bufRow", buf_row, 32'(prev % ROWS));
        checkOutput("bufWdata", buf_wdata, memData(addrOf(ba, bb, st, prev)));
      end
      if (k == 1) begin
        checkOutput("flagsAClr", flags_a, 0);
        checkOutput("flagsBClr", flags_b, 0);
      end
      checkOutput("allFlags", all_buf_flags, (k == expDone));
      checkOutput("busy", busy, (k < expDone));
      prev = expRd ? issued : -1;
      if (expRd) issued++;
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
    #12;
    checkOutput("rstMemRd", mem_rd, 0);
    checkOutput("rstBufWe", buf_we, 0);
    checkOutput("rstFlagsA", flags_a, 0);
    checkOutput("rstFlagsB", flags_b, 0);
    checkOutput("rstAll", all_buf_flags, 0);
    checkOutput("rstBusy", busy, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    $display("[TB] uncontended fill");
    runFill(32'h100, 32'h200, 16'h40, 0, -1, 10, 10);
    checkOutput("flagsAFull", flags_a, 4'hF);
    checkOutput("flagsBFull", flags_b, 4'hF);

    $display("[TB] contention on cycles 2 and 3");
    runFill(32'h100, 32'h200, 16'h40, 2, 3, 12, 12);
`ifdef SAD_BUF_FILL_STATS_EN
    checkOutput("stallCnt2", stall_cnt, 16'd2);
`endif

    $display("[TB] restart in FILL_B");
    runFill(32'h100, 32'h200, 16'h40, 0, -1, 10, 5);
    runFill(32'h800, 32'h900, 16'h10, 0, -1, 10, 10);

    $display("[TB] address wrap-around");
    runFill(32'hFFFFFFC0, 32'h00001000, 16'h20, 0, -1, 10, 10);

    $display("[TB] zero stride");
    runFill(32'h400, 32'h500, 16'h0, 0, -1, 10, 10);

    $display("[TB] reset mid-fill");
    runFill(32'h100, 32'h200, 16'h40, 0, -1, 10, 4);
    @(posedge Clk);
    #2;
    checkOutput("preRstBusy", busy, 1);
    checkOutput("preRstMemRd", mem_rd, 1);
    Rst_n = 1'b0;
    #1;
    checkOutput("midRstMemRd", mem_rd, 0);
    checkOutput("midRstAddr", mem_addr, 0);
    checkOutput("midRstBufWe", buf_we, 0);
    checkOutput("midRstWdata", buf_wdata, 0);
    checkOutput("midRstFlagsA", flags_a, 0);
    checkOutput("midRstFlagsB", flags_b, 0);
    checkOutput("midRstAll", all_buf_flags, 0);
    checkOutput("midRstBusy", busy, 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      #1;
      checkOutput("postRstBusy", busy, 0);
      checkOutput("postRstMemRd", mem_rd, 0);
      checkOutput("postRstAll", all_buf_flags, 0);
    end

`ifdef SAD_BUF_FILL_STATS_EN
    $display("[TB] stall counter saturation");
    @(negedge Clk);
    applyStimulus(1'b1, 32'h100, 32'h200, 16'h40, 1'b1);
    @(negedge Clk);
    applyStimulus(1'b0, 32'h100, 32'h200, 16'h40, 1'b1);
    repeat (69999) @(negedge Clk);
    #1;
    checkOutput("satStallCnt", stall_cnt, 16'hFFFF);
    checkOutput("satMemRd", mem_rd, 0);
    checkOutput("satBusy", busy, 1);
    checkOutput("satAll", all_buf_flags, 0);
    runFill(32'h100, 32'h200, 16'h40, 0, -1, 10, 10);
    checkOutput("stallCntClr", stall_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
